// File: rtl/out_sel_arb.sv
// Shared-pin output selector: routes one of N_SRC sources to the FND/LED/UART TX pins,
// draining the outgoing UART frame and blanking for a guard period on every switch.
// Optional build macro: OUT_SEL_ARB_DRAIN_TIMEOUT_EN bounds DRAIN to DRAIN_MAX cycles.
module out_sel_arb #(
    parameter int unsigned N_SRC     = 3,
    parameter int unsigned FND_COM_W = 4,
    parameter int unsigned FND_W     = 8,
    parameter int unsigned LED_W     = 5,
    parameter int unsigned BLANK_CYC = 1000,
    parameter int unsigned DRAIN_MAX = 200000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC-1:0]           start,
    input  logic                       stop,
    input  logic [N_SRC*FND_COM_W-1:0] src_fnd_com,
    input  logic [N_SRC*FND_W-1:0]     src_fnd,
    input  logic [N_SRC*LED_W-1:0]     src_led,
    input  logic [N_SRC-1:0]           src_tx,
    input  logic [N_SRC-1:0]           src_tx_busy,
    output logic [FND_COM_W-1:0]       fnd_com,
    output logic [FND_W-1:0]           fnd,
    output logic [LED_W-1:0]           led,
    output logic                       tx,
    output logic [N_SRC-1:0]           sel,
    output logic                       switching
);

    localparam int unsigned CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYC - 1);

    if (BLANK_CYC < 1 || DRAIN_MAX < 1) begin : g_param_chk
        $error("out_sel_arb: BLANK_CYC and DRAIN_MAX must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, BLANK} state_t;

    state_t               state_q, state_d;
    logic [N_SRC-1:0]     sel_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [IDX_W-1:0]     pend_idx_q, pend_idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FND_COM_W-1:0] fnd_com_d;
    logic [FND_W-1:0]     fnd_d;
    logic [LED_W-1:0]     led_d;
    logic                 tx_d;
    logic                 switching_d;

    logic                 start_any;
    logic [IDX_W-1:0]     req_idx;
    logic                 req_vld;
    logic                 req_self;
    logic                 drain_to;

    logic [FND_COM_W-1:0] mux_com;
    logic [FND_W-1:0]     mux_fnd;
    logic [LED_W-1:0]     mux_led;
    logic                 mux_tx;
    logic                 busy_sel;

`ifdef OUT_SEL_ARB_DRAIN_TIMEOUT_EN
    localparam int unsigned DCNT_W = $clog2(DRAIN_MAX + 1);
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    assign drain_to = (dcnt_q == DCNT_W'(DRAIN_MAX - 1));
`else
    assign drain_to = 1'b0;
`endif

    // Lowest set start bit wins; any start overrides stop.
    always_comb begin
        start_any = 1'b0;
        req_idx   = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (start[i]) begin
                start_any = 1'b1;
                req_idx   = IDX_W'(i);
            end
        end
    end

    assign req_vld  = start_any | stop;
    assign req_self = start_any & sel[req_idx];

    // Selected-source slice; one-hot sel makes the loop a plain mux.
    always_comb begin
        mux_com  = '1;
        mux_fnd  = '1;
        mux_led  = '0;
        mux_tx   = 1'b1;
        busy_sel = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (sel[i]) begin
                mux_com  = src_fnd_com[i*FND_COM_W +: FND_COM_W];
                mux_fnd  = src_fnd[i*FND_W +: FND_W];
                mux_led  = src_led[i*LED_W +: LED_W];
                mux_tx   = src_tx[i];
                busy_sel = src_tx_busy[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel        <= '0;
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            cnt_q      <= '0;
            fnd_com    <= '1;
            fnd        <= '1;
            led        <= '0;
            tx         <= 1'b1;
            switching  <= 1'b0;
`ifdef OUT_SEL_ARB_DRAIN_TIMEOUT_EN
            dcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel        <= sel_d;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            cnt_q      <= cnt_d;
            fnd_com    <= fnd_com_d;
            fnd        <= fnd_d;
            led        <= led_d;
            tx         <= tx_d;
            switching  <= switching_d;
`ifdef OUT_SEL_ARB_DRAIN_TIMEOUT_EN
            dcnt_q     <= dcnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel;
        pend_vld_d = pend_vld_q;
        pend_idx_d = pend_idx_q;
        cnt_d      = cnt_q;
        fnd_com_d  = '1;
        fnd_d      = '1;
        led_d      = '0;
        tx_d       = 1'b1;
`ifdef OUT_SEL_ARB_DRAIN_TIMEOUT_EN
        dcnt_d     = dcnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start_any) begin
                    state_d    = BLANK;
                    pend_vld_d = 1'b1;
                    pend_idx_d = req_idx;
                    cnt_d      = CNT_LOAD;
                end
            end
            ACTIVE: begin
                fnd_com_d = mux_com;
                fnd_d     = mux_fnd;
                led_d     = mux_led;
                tx_d      = mux_tx;
                if (req_vld && !req_self) begin
                    state_d    = DRAIN;
                    pend_vld_d = start_any;
                    pend_idx_d = req_idx;
`ifdef OUT_SEL_ARB_DRAIN_TIMEOUT_EN
                    dcnt_d     = '0;
`endif
                end
            end
            DRAIN: begin
                // Old source keeps the pins so its in-flight frame completes intact.
                fnd_com_d = mux_com;
                fnd_d     = mux_fnd;
                led_d     = mux_led;
                tx_d      = mux_tx;
                if (req_vld) begin
                    pend_vld_d = start_any;
                    pend_idx_d = req_idx;
                end
`ifdef OUT_SEL_ARB_DRAIN_TIMEOUT_EN
                dcnt_d = dcnt_q + DCNT_W'(1);
`endif
                if (!busy_sel || drain_to) begin
                    state_d = BLANK;
                    sel_d   = '0;
                    cnt_d   = CNT_LOAD;
                end
            end
            BLANK: begin
                if (req_vld) begin
                    pend_vld_d = start_any;
                    pend_idx_d = req_idx;
                end
                if (cnt_q == '0) begin
                    if (pend_vld_d) begin
                        state_d             = ACTIVE;
                        sel_d               = '0;
                        sel_d[pend_idx_d]   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                    pend_vld_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        switching_d = (state_d == DRAIN) || (state_d == BLANK);
    end

endmodule

// File: tb/tb_out_sel_arb.sv
// Scoreboard bench for out_sel_arb with BLANK_CYC=4, DRAIN_MAX=50.
// Expected output snapshots are queued as stimulus is driven and popped one per clock.
module tb_out_sel_arb;

    localparam int unsigned N_SRC     = 3;
    localparam int unsigned FND_COM_W = 4;
    localparam int unsigned FND_W     = 8;
    localparam int unsigned LED_W     = 5;
    localparam int unsigned BLANK_CYC = 4;
    localparam int unsigned DRAIN_MAX = 50;

    typedef struct packed {
        logic [3:0] fnd_com;
        logic [7:0] fnd;
        logic [4:0] led;
        logic       tx;
        logic [2:0] sel;
        logic       sw;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [N_SRC-1:0]           start;
    logic                       stop;
    logic [N_SRC*FND_COM_W-1:0] src_fnd_com;
    logic [N_SRC*FND_W-1:0]     src_fnd;
    logic [N_SRC*LED_W-1:0]     src_led;
    logic [N_SRC-1:0]           src_tx;
    logic [N_SRC-1:0]           src_tx_busy;
    logic [FND_COM_W-1:0]       fnd_com;
    logic [FND_W-1:0]           fnd;
    logic [LED_W-1:0]           led;
    logic                       tx;
    logic [N_SRC-1:0]           sel;
    logic                       switching;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    out_sel_arb #(
        .N_SRC(N_SRC), .FND_COM_W(FND_COM_W), .FND_W(FND_W), .LED_W(LED_W),
        .BLANK_CYC(BLANK_CYC), .DRAIN_MAX(DRAIN_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .src_fnd_com(src_fnd_com), .src_fnd(src_fnd), .src_led(src_led),
        .src_tx(src_tx), .src_tx_busy(src_tx_busy),
        .fnd_com(fnd_com), .fnd(fnd), .led(led), .tx(tx),
        .sel(sel), .switching(switching)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] com_of(int i);
        case (i)
            0:       return 4'hE;
            1:       return 4'hD;
            default: return 4'hB;
        endcase
    endfunction

    function automatic logic [7:0] fnd_of(int i);
        case (i)
            0:       return 8'h3C;
            1:       return 8'hA5;
            default: return 8'h5A;
        endcase
    endfunction

    function automatic logic [4:0] led_of(int i);
        case (i)
            0:       return 5'h11;
            1:       return 5'h0A;
            default: return 5'h15;
        endcase
    endfunction

    function automatic exp_t blank_e(logic [2:0] s, logic w);
        exp_t r;
        r.fnd_com = 4'hF; r.fnd = 8'hFF; r.led = 5'h00; r.tx = 1'b1; r.sel = s; r.sw = w;
        return r;
    endfunction

    function automatic exp_t pass_e(int i, logic t, logic [2:0] s, logic w);
        exp_t r;
        r.fnd_com = com_of(i); r.fnd = fnd_of(i); r.led = led_of(i); r.tx = t; r.sel = s; r.sw = w;
        return r;
    endfunction

    function automatic exp_t observe();
        exp_t r;
        r.fnd_com = fnd_com; r.fnd = fnd; r.led = led; r.tx = tx; r.sel = sel; r.sw = switching;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst_n = 1'b0; start = '0; stop = 1'b0; src_tx = '1; src_tx_busy = '0;
        repeat (2) step();
        rst_n = 1'b1;
        sb_q.push_back(blank_e(3'b000, 1'b0));
        repeat (10) step();
        e = sb_q.pop_front(); o = observe(); n_total++;
        if (o !== e) $display("FAIL reset: got %h want %h", o, e);
        else n_pass++;
    endtask

    // IDLE -> src1: 4 blank cycles, sel at cycle 5, data at cycle 6 (latency 5 after the start edge).
    task automatic test_latency();
        exp_t e, o;
        start = 3'b010;
        repeat (4) sb_q.push_back(blank_e(3'b000, 1'b1));
        sb_q.push_back(blank_e(3'b010, 1'b0));
        sb_q.push_back(pass_e(1, 1'b1, 3'b010, 1'b0));
        for (int k = 0; k < 6; k++) begin
            step();
            start = '0;
            e = sb_q.pop_front(); o = observe(); n_total++;
            if (o !== e) $display("FAIL latency[%0d]: got %h want %h", k, o, e);
            else n_pass++;
        end
    endtask

    // src1 busy for 20 cycles: tx keeps following src1 until busy drops, then blank, then src0.
    task automatic test_drain();
        exp_t e, o;
        logic v;
        start = 3'b001;
        for (int k = 0; k < 26; k++) begin
            v = 1'(k & 1);
            src_tx[1]      = v;
            src_tx_busy[1] = (k < 20);
            if (k < 20)       sb_q.push_back(pass_e(1, v, 3'b010, 1'b1));
            else if (k == 20) sb_q.push_back(pass_e(1, v, 3'b000, 1'b1));
            else if (k < 24)  sb_q.push_back(blank_e(3'b000, 1'b1));
            else if (k == 24) sb_q.push_back(blank_e(3'b001, 1'b0));
            else              sb_q.push_back(pass_e(0, 1'b1, 3'b001, 1'b0));
            step();
            start = '0;
            e = sb_q.pop_front(); o = observe(); n_total++;
            if (o !== e) $display("FAIL drain[%0d]: got %h want %h", k, o, e);
            else n_pass++;
        end
        src_tx[1] = 1'b1;
    endtask

    // stop with busy low: DRAIN one cycle, BLANK 4 cycles, then IDLE; stop in IDLE is ignored.
    task automatic test_stop();
        exp_t e, o;
        stop = 1'b1;
        sb_q.push_back(pass_e(0, 1'b1, 3'b001, 1'b1));
        sb_q.push_back(pass_e(0, 1'b1, 3'b000, 1'b1));
        repeat (3) sb_q.push_back(blank_e(3'b000, 1'b1));
        repeat (2) sb_q.push_back(blank_e(3'b000, 1'b0));
        for (int k = 0; k < 7; k++) begin
            step();
            stop = (k == 4);
            e = sb_q.pop_front(); o = observe(); n_total++;
            if (o !== e) $display("FAIL stop[%0d]: got %h want %h", k, o, e);
            else n_pass++;
        end
        stop = 1'b0;
    endtask

    // start=110 from IDLE selects src1; later start=010 with stop while on src1 changes nothing.
    task automatic test_priority();
        exp_t e, o;
        start = 3'b110;
        repeat (4) sb_q.push_back(blank_e(3'b000, 1'b1));
        sb_q.push_back(blank_e(3'b010, 1'b0));
        repeat (5) sb_q.push_back(pass_e(1, 1'b1, 3'b010, 1'b0));
        for (int k = 0; k < 10; k++) begin
            step();
            start = (k == 5) ? 3'b010 : 3'b000;
            stop  = (k == 5);
            e = sb_q.pop_front(); o = observe(); n_total++;
            if (o !== e) $display("FAIL priority[%0d]: got %h want %h", k, o, e);
            else n_pass++;
        end
        stop = 1'b0;
    endtask

    // Pending src0 overwritten by src2 mid-BLANK; guard count continues from where it was.
    task automatic test_blank_overwrite();
        exp_t e, o;
        start = 3'b001;
        sb_q.push_back(pass_e(1, 1'b1, 3'b010, 1'b1));
        sb_q.push_back(pass_e(1, 1'b1, 3'b000, 1'b1));
        repeat (3) sb_q.push_back(blank_e(3'b000, 1'b1));
        sb_q.push_back(blank_e(3'b100, 1'b0));
        sb_q.push_back(pass_e(2, 1'b1, 3'b100, 1'b0));
        for (int k = 0; k < 7; k++) begin
            step();
            start = (k == 1) ? 3'b100 : 3'b000;
            e = sb_q.pop_front(); o = observe(); n_total++;
            if (o !== e) $display("FAIL blank_overwrite[%0d]: got %h want %h", k, o, e);
            else n_pass++;
        end
    endtask

    // Reset pulled low mid-BLANK must clear outputs without a clock edge.
    task automatic test_reset_mid_blank();
        exp_t e, o;
        start = 3'b001;
        sb_q.push_back(pass_e(2, 1'b1, 3'b100, 1'b1));
        sb_q.push_back(pass_e(2, 1'b1, 3'b000, 1'b1));
        sb_q.push_back(blank_e(3'b000, 1'b1));
        for (int k = 0; k < 3; k++) begin
            step();
            start = '0;
            e = sb_q.pop_front(); o = observe(); n_total++;
            if (o !== e) $display("FAIL reset_mid_blank[%0d]: got %h want %h", k, o, e);
            else n_pass++;
        end
        #2;
        rst_n = 1'b0;
        sb_q.push_back(blank_e(3'b000, 1'b0));
        #1;
        e = sb_q.pop_front(); o = observe(); n_total++;
        if (o !== e) $display("FAIL async_reset: got %h want %h", o, e);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
    endtask

`ifdef OUT_SEL_ARB_DRAIN_TIMEOUT_EN
    // Stuck-busy src1: BLANK entered exactly DRAIN_MAX cycles after DRAIN entry.
    task automatic test_drain_timeout();
        exp_t e, o;
        start = 3'b010;
        repeat (6) step();
        start = '0;
        src_tx_busy[1] = 1'b1;
        step();
        start = 3'b001;
        for (int k = 0; k <= 51; k++) begin
            if (k < 50)       sb_q.push_back(pass_e(1, 1'b1, 3'b010, 1'b1));
            else if (k == 50) sb_q.push_back(pass_e(1, 1'b1, 3'b000, 1'b1));
            else              sb_q.push_back(blank_e(3'b000, 1'b1));
            step();
            start = '0;
            e = sb_q.pop_front(); o = observe(); n_total++;
            if (o !== e) $display("FAIL drain_timeout[%0d]: got %h want %h", k, o, e);
            else n_pass++;
        end
        src_tx_busy[1] = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask
`endif

    initial begin
        src_fnd_com = {com_of(2), com_of(1), com_of(0)};
        src_fnd     = {fnd_of(2), fnd_of(1), fnd_of(0)};
        src_led     = {led_of(2), led_of(1), led_of(0)};
        test_reset();
        test_latency();
        test_drain();
        test_stop();
        test_priority();
        test_blank_overwrite();
        test_reset_mid_blank();
`ifdef OUT_SEL_ARB_DRAIN_TIMEOUT_EN
        test_drain_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
